// File: rtl/i2s_receiver_if.sv
// rtl/i2s_receiver_if.sv - I2S receive pins and decoded PCM outputs
interface i2s_receiver_if #(
  parameter int WIDTH = 16
);
  logic             sclk;
  logic             lrclk;
  logic             sdin;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             sample_valid;
  logic             frame_error;

  // Source side: drives the serial pins, observes the decoded words
  modport master (
    output sclk, lrclk, sdin,
    input  left, right, sample_valid, frame_error
  );

  // Receiver side
  modport slave (
    input  sclk, lrclk, sdin,
    output left, right, sample_valid, frame_error
  );
endinterface

// File: rtl/i2s_receiver.sv
// rtl/i2s_receiver.sv - I2S deserializer recovering 16-bit left/right PCM pairs
module i2s_receiver #(
  parameter int NUM_OF_AMPLITUDE_BITS = 16,
  parameter int SYNC_STAGES           = 2
) (
  input  logic          i_Clk,
  input  logic          i_Rst,
  i2s_receiver_if.slave bus
);
  localparam int N  = NUM_OF_AMPLITUDE_BITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] FULL = CW'(N);

  typedef enum logic [1:0] {S_SYNC, S_LEFT, S_RIGHT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sclk_prev;

  logic sclk_s;
  logic lr_s;
  logic sd_s;
  logic sample;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign lr_s   = lr_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];
  // LRCLK/SDIN travel through equal-depth chains, so they line up with the SCLK edge
  assign sample = sclk_prev & ~sclk_s;

  // Identical synchronizer chains plus one extra SCLK flop for falling-edge detect
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], bus.lrclk};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], bus.sdin};
      sclk_prev <= sclk_s;
    end
  end

  state_t        state;
  logic          lr_prev;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  shift_reg;
  logic [N-1:0]  left_hold;
  logic [N-1:0]  left_q;
  logic [N-1:0]  right_q;
  logic          publish;
  logic          valid_q;
  logic          error_q;

  logic [N-1:0]  shifted;
  logic          boundary;

  assign shifted  = {shift_reg[N-2:0], sd_s};
  assign boundary = (lr_s != lr_prev);

  // Channel framing FSM; publish is staged one cycle so the pair updates together with the strobe
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= S_SYNC;
      lr_prev   <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      left_hold <= '0;
      left_q    <= '0;
      right_q   <= '0;
      publish   <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= publish;
      publish <= 1'b0;
      error_q <= 1'b0;
      if (publish) begin
        left_q  <= left_hold;
        right_q <= shift_reg;
      end
      if (sample) begin
        lr_prev <= lr_s;
        case (state)
          S_SYNC: begin
            if (!lr_s && lr_prev) begin
              shift_reg <= N'(sd_s);
              bit_cnt   <= CW'(1);
              state     <= S_LEFT;
            end
          end
          S_LEFT: begin
            if (!boundary) begin
              if (bit_cnt == FULL) begin
                error_q <= 1'b1;
                state   <= S_SYNC;
              end else begin
                shift_reg <= shifted;
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == FULL - 1'b1) begin
                  left_hold <= shifted;
                end
              end
            end else if (bit_cnt == FULL) begin
              shift_reg <= N'(sd_s);
              bit_cnt   <= CW'(1);
              state     <= S_RIGHT;
            end else begin
              error_q <= 1'b1;
              state   <= S_SYNC;
            end
          end
          S_RIGHT: begin
            if (!boundary) begin
              if (bit_cnt == FULL) begin
                error_q <= 1'b1;
                state   <= S_SYNC;
              end else begin
                shift_reg <= shifted;
                bit_cnt   <= bit_cnt + 1'b1;
                if (bit_cnt == FULL - 1'b1) begin
                  publish <= 1'b1;
                end
              end
            end else begin
              // A short right word is dropped, but this edge still starts a left channel
              if (bit_cnt != FULL) begin
                error_q <= 1'b1;
              end
              shift_reg <= N'(sd_s);
              bit_cnt   <= CW'(1);
              state     <= S_LEFT;
            end
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

  assign bus.left         = left_q;
  assign bus.right        = right_q;
  assign bus.sample_valid = valid_q;
  assign bus.frame_error  = error_q;
endmodule

// File: tb/tb_i2s_receiver.sv
// tb/tb_i2s_receiver.sv - self-checking bench for i2s_receiver
module tb_i2s_receiver;
  localparam int N  = 16;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_fall_cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   both_cnt = 0;

  i2s_receiver_if #(.WIDTH(N)) bus ();

  i2s_receiver #(
    .NUM_OF_AMPLITUDE_BITS(N),
    .SYNC_STAGES(SS)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  typedef struct {
    bit          valid;
    logic [15:0] l;
    logic [15:0] r;
    int          lat;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  // Record every strobe the DUT produces
  always @(negedge clk) begin
    if (bus.sample_valid && bus.frame_error) both_cnt++;
    if (bus.sample_valid)
      obs_q.push_back('{valid: 1'b1, l: bus.left, r: bus.right, lat: cyc - last_fall_cyc});
    else if (bus.frame_error)
      obs_q.push_back('{valid: 1'b0, l: 16'h0, r: 16'h0, lat: 0});
  end

  // Reference model: tracks channel runs on the received sample stream
  bit          m_sync;
  logic        m_prev;
  int          m_len;
  logic [15:0] m_word;
  logic [15:0] m_lw;
  logic [15:0] m_left;
  logic [15:0] m_right;

  task automatic model_reset();
    m_sync = 0; m_prev = 1'b0; m_len = 0; m_word = '0;
    m_lw = '0; m_left = '0; m_right = '0;
  endtask

  task automatic push_err();
    exp_q.push_back('{valid: 1'b0, l: 16'h0, r: 16'h0, lat: 0});
  endtask

  task automatic model_sample(input logic lr, input logic b);
    if (lr != m_prev) begin
      if (m_sync) begin
        if (m_prev == 1'b0) begin
          if (m_len == N) begin
            m_lw = m_word; m_len = 1; m_word = {15'b0, b};
          end else begin
            push_err(); m_sync = 0;
          end
        end else begin
          if (m_len != N) push_err();
          m_len = 1; m_word = {15'b0, b};
        end
      end else if (lr == 1'b0) begin
        m_sync = 1; m_len = 1; m_word = {15'b0, b};
      end
    end else if (m_sync) begin
      m_len++;
      m_word = {m_word[14:0], b};
      if (m_len == N + 1) begin
        push_err(); m_sync = 0;
      end else if (m_len == N && lr) begin
        m_left = m_lw; m_right = m_word;
        exp_q.push_back('{valid: 1'b1, l: m_lw, r: m_word, lat: SS + 2});
      end
    end
    m_prev = lr;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // TX model: data/LRCLK change on SCLK rising, SCLK = i_Clk/16
  task automatic send_bit(input logic lr, input logic b);
    bus.sclk = 1'b1; bus.lrclk = lr; bus.sdin = b;
    #80;
    bus.sclk = 1'b0;
    last_fall_cyc = cyc;
    model_sample(lr, b);
    #80;
  endtask

  task automatic send_word(input logic lr, input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) send_bit(lr, (i < N) ? w[N-1-i] : 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.sclk = 1'b0;
    model_reset();
    #50;
    rst = 1'b0;
    #50;
  endtask

  task automatic compare_events(input string name);
    int n;
    #400;
    chk({name, " event count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({name, " event kind"}, obs_q[i].valid, exp_q[i].valid);
      if (obs_q[i].valid && exp_q[i].valid) begin
        chk({name, " left word"}, obs_q[i].l, exp_q[i].l);
        chk({name, " right word"}, obs_q[i].r, exp_q[i].r);
        chk({name, " latency"}, obs_q[i].lat, exp_q[i].lat);
      end
    end
    chk({name, " held left"}, bus.left, m_left);
    chk({name, " held right"}, bus.right, m_right);
    obs_q.delete();
    exp_q.delete();
  endtask

  typedef struct {
    int          nl;
    int          nr;
    logic [15:0] l;
    logic [15:0] r;
    int          exp_valid;
    int          exp_err;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
  } vec_t;

  vec_t vt[7];

  initial begin
    int nv, ne, nl, nr;
    vt[0] = '{16, 16, 16'hA5C3, 16'h3C5A, 1, 0, 16'hA5C3, 16'h3C5A};
    vt[1] = '{12, 16, 16'h1111, 16'h2222, 0, 1, 16'h0000, 16'h0000};
    vt[2] = '{16, 17, 16'hFFFF, 16'h0001, 1, 1, 16'hFFFF, 16'h0001};
    vt[3] = '{16, 12, 16'h4444, 16'h5555, 0, 1, 16'h0000, 16'h0000};
    vt[4] = '{17, 16, 16'h6666, 16'h7777, 0, 1, 16'h0000, 16'h0000};
    vt[5] = '{16, 16, 16'h8000, 16'h7FFF, 1, 0, 16'h8000, 16'h7FFF};
    vt[6] = '{16, 16, 16'h0000, 16'h8000, 1, 0, 16'h0000, 16'h8000};

    bus.sclk = 1'b0; bus.lrclk = 1'b0; bus.sdin = 1'b0;
    model_reset();
    #8;

    // Table of single framed channel pairs, each from a fresh reset
    for (int k = 0; k < 7; k++) begin
      do_reset();
      send_bit(1'b1, 1'b0);
      send_word(1'b0, vt[k].l, vt[k].nl);
      send_word(1'b1, vt[k].r, vt[k].nr);
      send_bit(1'b0, 1'b0);
      #400;
      nv = 0; ne = 0;
      foreach (obs_q[i]) if (obs_q[i].valid) nv++; else ne++;
      chk($sformatf("vec%0d valid count", k), nv, vt[k].exp_valid);
      chk($sformatf("vec%0d error count", k), ne, vt[k].exp_err);
      chk($sformatf("vec%0d left", k), bus.left, vt[k].exp_left);
      chk($sformatf("vec%0d right", k), bus.right, vt[k].exp_right);
      compare_events($sformatf("vec%0d", k));
    end

    // Asynchronous reset between clock edges clears outputs at once
    rst = 1'b1;
    #1;
    chk("async reset left", bus.left, 16'h0);
    chk("async reset right", bus.right, 16'h0);
    chk("async reset valid", bus.sample_valid, 1'b0);
    chk("async reset error", bus.frame_error, 1'b0);
    #9;
    model_reset();
    obs_q.delete(); exp_q.delete();
    #40;
    rst = 1'b0;
    #2000;
    chk("idle sclk pulses", obs_q.size(), 0);

    // Start inside a right channel: partial word never published
    do_reset();
    send_word(1'b1, 16'hBEEF, 5);
    send_word(1'b0, 16'h1357, 16);
    send_word(1'b1, 16'h2468, 16);
    send_bit(1'b0, 1'b0);
    #400;
    chk("midframe left", bus.left, 16'h1357);
    chk("midframe right", bus.right, 16'h2468);
    compare_events("midframe");

    // Long right, then back-to-back frames after resync
    do_reset();
    send_bit(1'b1, 1'b0);
    send_word(1'b0, 16'hAAAA, 16);
    send_word(1'b1, 16'h5555, 17);
    send_word(1'b0, 16'hFFFF, 16);
    send_word(1'b1, 16'h0001, 16);
    send_word(1'b0, 16'h0000, 16);
    send_word(1'b1, 16'h8000, 16);
    send_bit(1'b0, 1'b0);
    #400;
    chk("b2b final left", bus.left, 16'h0000);
    chk("b2b final right", bus.right, 16'h8000);
    compare_events("longright_b2b");

    // Reset after 7 bits of a left word
    do_reset();
    send_bit(1'b1, 1'b0);
    send_word(1'b0, 16'h0F0F, 16);
    send_word(1'b1, 16'hF0F0, 16);
    send_word(1'b0, 16'h1234, 7);
    compare_events("pre_reset");
    rst = 1'b1;
    #1;
    chk("midword reset left", bus.left, 16'h0);
    chk("midword reset right", bus.right, 16'h0);
    #9;
    bus.sclk = 1'b0;
    model_reset();
    #40;
    rst = 1'b0;
    #50;
    send_bit(1'b1, 1'b0);
    send_word(1'b0, 16'h1234, 16);
    send_word(1'b1, 16'hABCD, 16);
    send_bit(1'b0, 1'b0);
    #400;
    chk("post reset left", bus.left, 16'h1234);
    chk("post reset right", bus.right, 16'hABCD);
    compare_events("midword_reset");

    // Random frames with occasional short/long channels
    do_reset();
    send_bit(1'b1, 1'b0);
    for (int f = 0; f < 40; f++) begin
      nl = $urandom_range(0, 9);
      nl = (nl == 0) ? 15 : (nl == 1) ? 17 : 16;
      nr = $urandom_range(0, 9);
      nr = (nr == 0) ? 15 : (nr == 1) ? 17 : 16;
      send_word(1'b0, 16'($urandom), nl);
      send_word(1'b1, 16'($urandom), nr);
    end
    send_bit(1'b0, 1'b0);
    compare_events("random");

    chk("valid/error overlap", both_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
